// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC and issues pipelined instruction-memory reads under a credit limit.
// Returned words are paired with their PC tags and buffered, then presented to IF/ID.
// A flush redirects the PC, empties the buffers and arms a counter that discards the
// responses of reads that were already in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr
);

    // Pointer width and counter width (counters must hold the value FIFO_DEPTH).
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

    // Architectural state.
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    // PC tag queue: one entry per accepted read whose response will be kept.
    logic [31:0]   tag_mem_q [FIFO_DEPTH];
    logic [PW-1:0] tag_wr_q, tag_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;
    logic [CW-1:0] tag_cnt_q, tag_cnt_d;

    // Fetch buffer holding {pc, instr} pairs waiting for decode.
    logic [31:0]   buf_pc_q [FIFO_DEPTH];
    logic [31:0]   buf_instr_q [FIFO_DEPTH];
    logic [PW-1:0] buf_wr_q, buf_wr_d;
    logic [PW-1:0] buf_rd_q, buf_rd_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;

    // Handshake qualifiers.
    logic credit_ok;
    logic issue;
    logic rsp;
    logic rsp_drop;
    logic rsp_keep;
    logic pop;

    // The low address bits of the redirect target are ignored by design.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    // Request, response and consume qualifiers, plus the IF/ID presentation.
    always_comb begin
        credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_cnt_q}) < DEPTH_EXT;
        o_imem_req_valid = !i_rst && !i_flush && credit_ok;
        o_imem_req_addr  = pc_q;
        issue            = o_imem_req_valid && i_imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp      = i_imem_rsp_valid && (outstanding_q != '0);
        rsp_drop = rsp && (i_flush || (drop_cnt_q != '0));
        rsp_keep = rsp && !rsp_drop;

        o_if_valid = !i_rst && (buf_cnt_q != '0);
        o_if_pc    = o_if_valid ? buf_pc_q[buf_rd_q] : 32'h0;
        o_if_instr = o_if_valid ? buf_instr_q[buf_rd_q] : 32'h0;
        pop        = o_if_valid && !i_stall && !i_flush;
    end

    // Next-state computation; flush overrides every other update.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        tag_cnt_d     = tag_cnt_q;
        buf_wr_d      = buf_wr_q;
        buf_rd_d      = buf_rd_q;
        buf_cnt_d     = buf_cnt_q;

        if (i_flush) begin
            pc_d          = {i_redirect_pc[31:2], 2'b00};
            outstanding_d = outstanding_q - CW'(rsp);
            // Everything still in flight after this cycle belongs to the old stream.
            drop_cnt_d    = outstanding_q - CW'(rsp);
            tag_wr_d      = '0;
            tag_rd_d      = '0;
            tag_cnt_d     = '0;
            buf_wr_d      = '0;
            buf_rd_d      = '0;
            buf_cnt_d     = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);
            if (rsp && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end

            tag_wr_d  = tag_wr_q + PW'(issue);
            tag_rd_d  = tag_rd_q + PW'(rsp_keep);
            tag_cnt_d = tag_cnt_q + CW'(issue) - CW'(rsp_keep);

            buf_wr_d  = buf_wr_q + PW'(rsp_keep);
            buf_rd_d  = buf_rd_q + PW'(pop);
            buf_cnt_d = buf_cnt_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            tag_cnt_q     <= '0;
            buf_wr_q      <= '0;
            buf_rd_q      <= '0;
            buf_cnt_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_cnt_q     <= tag_cnt_d;
            buf_wr_q      <= buf_wr_d;
            buf_rd_q      <= buf_rd_d;
            buf_cnt_q     <= buf_cnt_d;
        end
    end

    // Storage arrays: tag written on issue, buffer written on a kept response.
    always_ff @(posedge i_clk) begin
        if (!i_rst && issue) begin
            tag_mem_q[tag_wr_q] <= pc_q;
        end
        if (!i_rst && rsp_keep) begin
            buf_pc_q[buf_wr_q]    <= tag_mem_q[tag_rd_q];
            buf_instr_q[buf_wr_q] <= i_imem_rsp_data;
        end
    end

`ifndef SYNTHESIS
    // Protocol and structural invariants checked in simulation only.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_imem_rsp_valid && (outstanding_q == '0)))
            else $error("fetch_unit: response with no outstanding read");
            assert (({1'b0, outstanding_q} + {1'b0, buf_cnt_q}) <= DEPTH_EXT)
            else $error("fetch_unit: credit overrun out=%0d buf=%0d", outstanding_q, buf_cnt_q);
            assert (drop_cnt_q <= outstanding_q)
            else $error("fetch_unit: drop=%0d exceeds out=%0d", drop_cnt_q, outstanding_q);
            assert (o_imem_req_addr[1:0] == 2'b00)
            else $error("fetch_unit: misaligned request address %h", o_imem_req_addr);
            assert (tag_cnt_q == (outstanding_q - drop_cnt_q))
            else $error("fetch_unit: tag count %0d out of step", tag_cnt_q);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order instruction-memory model.
module tb_fetch_unit;

    logic        i_clk;
    logic        i_rst;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_if_valid;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_instr;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_stall          (i_stall),
        .i_flush          (i_flush),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_if_valid       (o_if_valid),
        .o_if_pc          (o_if_pc),
        .o_if_instr       (o_if_instr)
    );

    int total = 0;
    int bad   = 0;

    // Memory model state.
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc        = 0;
    int          lat        = 1;
    int          issues     = 0;
    bit          rand_ready = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: record accepts/responses at the edge, then drive the next response.
    task automatic tick();
        logic        iss;
        logic        rv;
        logic        rs;
        logic [31:0] ia;
        #2;
        iss = o_imem_req_valid && i_imem_req_ready;
        ia  = o_imem_req_addr;
        rv  = i_imem_rsp_valid;
        rs  = i_rst;
        @(posedge i_clk);
        cyc++;
        if (rs) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (rv) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (iss) begin
                pend_addr.push_back(ia);
                pend_due.push_back(cyc + lat - 1);
                issues++;
            end
        end
        #1;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem_word(pend_addr[0]);
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = 32'h0;
        end
        if (rand_ready) i_imem_req_ready = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    // Advance until an instruction is presented (bounded), then check it.
    task automatic get_out(input string tag, input logic [31:0] exp_pc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!o_if_valid && n < 20);
        chk({tag, "_valid"}, 32'(o_if_valid), 32'd1);
        chk({tag, "_pc"}, o_if_pc, exp_pc);
        chk({tag, "_instr"}, o_if_instr, mem_word(exp_pc));
    endtask

    initial begin : main
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        logic [31:0] redir;
        bit          do_flush;
        bit          saw_wrap;
        int          issues0;
        int          consumed;
        int          n;

        i_rst            = 1'b1;
        i_stall          = 1'b0;
        i_flush          = 1'b0;
        i_redirect_pc    = 32'h0;
        i_imem_req_ready = 1'b1;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'h0;

        // Reset state.
        tick();
        chk("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(o_if_valid), 32'd0);
        chk("rst_req_addr", o_imem_req_addr, 32'h0);
        chk("rst_if_pc", o_if_pc, 32'h0);
        chk("rst_if_instr", o_if_instr, 32'h0);
        tick();
        i_rst = 1'b0;

        // Basic streaming: 0 accepted, 4 offered next cycle, first output two cycles later.
        tick();
        chk("s1_if_valid", 32'(o_if_valid), 32'd0);
        chk("s1_req_addr", o_imem_req_addr, 32'h4);
        chk("s1_req_valid", 32'(o_imem_req_valid), 32'd1);
        tick();
        chk("s1_out0_valid", 32'(o_if_valid), 32'd1);
        chk("s1_out0_pc", o_if_pc, 32'h0);
        chk("s1_out0_instr", o_if_instr, mem_word(32'h0));
        get_out("s1_out4", 32'h4);
        get_out("s1_out8", 32'h8);

        // Stall with head pc=8: output frozen, credit runs out, then resumes at 0xC.
        i_stall = 1'b1;
        issues0 = issues;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(o_if_valid), 32'd1);
            chk("stall_pc", o_if_pc, 32'h8);
            chk("stall_instr", o_if_instr, mem_word(32'h8));
        end
        chk("stall_new_issues", 32'(issues - issues0), 32'd0);
        chk("stall_no_credit", 32'(o_imem_req_valid), 32'd0);
        i_stall = 1'b0;
        get_out("stall_rel_c", 32'hC);
        get_out("stall_rel_10", 32'h10);

        // Drain, then build two long-latency reads in flight with an empty buffer.
        i_imem_req_ready = 1'b0;
        i_stall          = 1'b1;
        tick();
        tick();
        i_stall          = 1'b0;
        lat              = 4;
        i_imem_req_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("fl_setup_empty", 32'(o_if_valid), 32'd0);
        chk("fl_setup_inflight", 32'(pend_addr.size()), 32'd2);
        chk("fl_setup_no_credit", 32'(o_imem_req_valid), 32'd0);

        // Flush to 0x103: the two late responses must be discarded.
        i_flush       = 1'b1;
        i_redirect_pc = 32'h103;
        #1;
        chk("fl_no_req", 32'(o_imem_req_valid), 32'd0);
        tick();
        i_flush = 1'b0;
        chk("fl_req_addr", o_imem_req_addr, 32'h100);
        chk("fl_if_valid", 32'(o_if_valid), 32'd0);
        get_out("fl_out100", 32'h100);
        get_out("fl_out104", 32'h104);
        lat = 1;

        // Flush coinciding with a response, then a second flush on the next cycle.
        n = 0;
        while (!i_imem_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("ff_rsp_seen", 32'(i_imem_rsp_valid), 32'd1);
        i_flush       = 1'b1;
        i_redirect_pc = 32'h200;
        tick();
        i_redirect_pc = 32'h300;
        tick();
        i_flush = 1'b0;
        chk("ff_if_valid", 32'(o_if_valid), 32'd0);
        chk("ff_req_addr", o_imem_req_addr, 32'h300);
        get_out("ff_out300", 32'h300);
        get_out("ff_out304", 32'h304);
        get_out("ff_out308", 32'h308);
        chk("ff_drop_zero", 32'(dut.drop_cnt_q), 32'd0);

        // Random ready, latency and stall; wrap past 0xFFFF_FFFC; late random flushes.
        i_flush       = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF2;
        tick();
        i_flush    = 1'b0;
        exp_pc     = 32'hFFFF_FFF0;
        prev_pc    = 32'h0;
        saw_wrap   = 1'b0;
        consumed   = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            lat      = $urandom_range(1, 4);
            i_stall  = ($urandom_range(0, 3) == 0);
            do_flush = (i >= 200) && ($urandom_range(0, 24) == 0);
            redir    = $urandom;
            i_flush  = do_flush;
            i_redirect_pc = redir;
            if (o_if_valid && !i_stall && !do_flush) begin
                chk("rnd_pc", o_if_pc, exp_pc);
                chk("rnd_instr", o_if_instr, mem_word(exp_pc));
                if (consumed > 0 && prev_pc == 32'hFFFF_FFFC && o_if_pc == 32'h0) saw_wrap = 1'b1;
                prev_pc = o_if_pc;
                exp_pc  = exp_pc + 32'd4;
                consumed++;
            end
            if (do_flush) exp_pc = {redir[31:2], 2'b00};
            tick();
        end
        i_flush          = 1'b0;
        i_stall          = 1'b0;
        rand_ready       = 1'b0;
        i_imem_req_ready = 1'b1;
        chk("rnd_wrap_seen", 32'(saw_wrap), 32'd1);
        chk("rnd_progress", 32'(consumed > 40), 32'd1);

        // Reset in the middle of traffic with two reads outstanding.
        lat = 4;
        n   = 0;
        while (pend_addr.size() != 2 && n < 40) begin
            tick();
            n++;
        end
        chk("mr_setup_inflight", 32'(pend_addr.size()), 32'd2);
        i_rst = 1'b1;
        #1;
        chk("mr_req_valid_in_rst", 32'(o_imem_req_valid), 32'd0);
        chk("mr_if_valid_in_rst", 32'(o_if_valid), 32'd0);
        tick();
        chk("mr_if_valid", 32'(o_if_valid), 32'd0);
        chk("mr_req_addr", o_imem_req_addr, 32'h0);
        chk("mr_outstanding", 32'(dut.outstanding_q), 32'd0);
        chk("mr_drop", 32'(dut.drop_cnt_q), 32'd0);
        chk("mr_buf_cnt", 32'(dut.buf_cnt_q), 32'd0);
        i_rst = 1'b0;
        lat   = 1;
        get_out("mr_out0", 32'h0);
        get_out("mr_out4", 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
